// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records displaced physical D/S registers per dispatched
// instruction and returns them as one-hot masks to the free list when the entry retires.
module reorder_buffer #(
   parameter int NUM_ENTRIES = 16,
   parameter int NUM_D_REG   = 32,
   parameter int NUM_S_REG   = 8
) (
   input  logic                           clk,
   input  logic                           n_rst,
   input  logic                           alloc_valid,
   input  logic                           alloc_use_rw,
   input  logic [$clog2(NUM_D_REG)-1:0]   alloc_prev_rw,
   input  logic                           alloc_use_rs,
   input  logic [$clog2(NUM_S_REG)-1:0]   alloc_prev_rs,
   output logic [$clog2(NUM_ENTRIES)-1:0] alloc_tag,
   output logic                           stall,
   input  logic                           complete_valid,
   input  logic [$clog2(NUM_ENTRIES)-1:0] complete_tag,
   output logic                           commit_valid,
   output logic [$clog2(NUM_ENTRIES)-1:0] commit_tag,
   output logic [NUM_D_REG-1:0]           return_r_list,
   output logic [NUM_S_REG-1:0]           return_s_list,
   output logic                           empty
);

   localparam int TW = $clog2(NUM_ENTRIES);
   localparam int CW = TW + 1;
   localparam int RW = $clog2(NUM_D_REG);
   localparam int SW = $clog2(NUM_S_REG);

   localparam logic [TW-1:0] TAG_ONE  = TW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(NUM_ENTRIES);

   logic [TW-1:0]          head;
   logic [TW-1:0]          tail;
   logic [CW-1:0]          count;
   logic [NUM_ENTRIES-1:0] valid;
   logic [NUM_ENTRIES-1:0] done;
   logic [NUM_ENTRIES-1:0] use_rw;
   logic [NUM_ENTRIES-1:0] use_rs;
   logic [RW-1:0]          prev_rw [NUM_ENTRIES];
   logic [SW-1:0]          prev_rs [NUM_ENTRIES];

   logic full;
   logic alloc_ok;

   assign full         = (count == CNT_FULL);
   assign alloc_ok     = alloc_valid & ~full;
   assign stall        = alloc_valid & full;
   assign empty        = (count == '0);
   assign alloc_tag    = tail;
   assign commit_tag   = head;
   assign commit_valid = (count != '0) & valid[head] & done[head];

   always_comb begin
      return_r_list = '0;
      return_s_list = '0;
      if (commit_valid && use_rw[head]) return_r_list[prev_rw[head]] = 1'b1;
      if (commit_valid && use_rs[head]) return_s_list[prev_rs[head]] = 1'b1;
   end

   // Assignment order matters: completion, then the head clear on commit, then the
   // tail write. Tail can only equal head with a commit when the buffer is full, and
   // allocation is refused then, so the commit clear and the tail write never collide.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         done  <= '0;
      end else begin
         if (complete_valid && valid[complete_tag]) done[complete_tag] <= 1'b1;

         if (commit_valid) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
            head        <= head + TAG_ONE;
         end

         if (alloc_ok) begin
            valid[tail]   <= 1'b1;
            done[tail]    <= 1'b0;
            use_rw[tail]  <= alloc_use_rw;
            prev_rw[tail] <= alloc_prev_rw;
            use_rs[tail]  <= alloc_use_rs;
            prev_rs[tail] <= alloc_prev_rs;
            tail          <= tail + TAG_ONE;
         end

         case ({alloc_ok, commit_valid})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset, single retire, out-of-order
// completion, full/stall with wrap, status-only return and mid-operation reset.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        alloc_valid;
   logic        alloc_use_rw;
   logic [4:0]  alloc_prev_rw;
   logic        alloc_use_rs;
   logic [2:0]  alloc_prev_rs;
   logic [3:0]  alloc_tag;
   logic        stall;
   logic        complete_valid;
   logic [3:0]  complete_tag;
   logic        commit_valid;
   logic [3:0]  commit_tag;
   logic [31:0] return_r_list;
   logic [7:0]  return_s_list;
   logic        empty;

   int errors = 0;
   int checks = 0;

   reorder_buffer #(.NUM_ENTRIES(16), .NUM_D_REG(32), .NUM_S_REG(8)) dut (
      .clk(clk), .n_rst(n_rst),
      .alloc_valid(alloc_valid), .alloc_use_rw(alloc_use_rw), .alloc_prev_rw(alloc_prev_rw),
      .alloc_use_rs(alloc_use_rs), .alloc_prev_rs(alloc_prev_rs),
      .alloc_tag(alloc_tag), .stall(stall),
      .complete_valid(complete_valid), .complete_tag(complete_tag),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .return_r_list(return_r_list), .return_s_list(return_s_list), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid    = 1'b0;
      alloc_use_rw   = 1'b0;
      alloc_prev_rw  = '0;
      alloc_use_rs   = 1'b0;
      alloc_prev_rs  = '0;
      complete_valid = 1'b0;
      complete_tag   = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got=%b exp=0", commit_valid); end
      checks++; if (return_r_list !== 32'h0) begin errors++; $display("FAIL reset_return_r got=%h exp=0", return_r_list); end
      checks++; if (return_s_list !== 8'h0) begin errors++; $display("FAIL reset_return_s got=%h exp=0", return_s_list); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
      checks++; if (commit_tag !== 4'd0) begin errors++; $display("FAIL reset_commit_tag got=%0d exp=0", commit_tag); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      tick();
      checks++; if (commit_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL idle_after_reset commit=%b empty=%b exp commit=0 empty=1", commit_valid, empty); end
   endtask

   task automatic test_single();
      apply_reset();
      alloc_valid = 1'b1; alloc_use_rw = 1'b1; alloc_prev_rw = 5'd5;
      checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL single_alloc_tag got=%0d exp=0", alloc_tag); end
      tick();
      idle_inputs();
      complete_valid = 1'b1; complete_tag = 4'd0;
      checks++; if (commit_valid !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL single_pre_commit commit=%b empty=%b exp commit=0 empty=0", commit_valid, empty); end
      tick();
      complete_valid = 1'b0;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'd0) begin errors++; $display("FAIL single_commit commit=%b tag=%0d exp commit=1 tag=0", commit_valid, commit_tag); end
      checks++; if (return_r_list !== 32'h0000_0020) begin errors++; $display("FAIL single_return_r got=%h exp=00000020", return_r_list); end
      checks++; if (return_s_list !== 8'h00) begin errors++; $display("FAIL single_return_s got=%h exp=00", return_s_list); end
      tick();
      checks++; if (empty !== 1'b1 || commit_valid !== 1'b0 || return_r_list !== 32'h0) begin errors++; $display("FAIL single_drained empty=%b commit=%b r=%h exp empty=1 commit=0 r=0", empty, commit_valid, return_r_list); end
   endtask

   task automatic test_out_of_order();
      logic [31:0] exp_r;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1; alloc_use_rw = 1'b1; alloc_prev_rw = 5'(10 + i);
         tick();
      end
      idle_inputs();
      for (int t = 2; t >= 0; t--) begin
         complete_valid = 1'b1; complete_tag = 4'(t);
         checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_no_early_commit completing=%0d got=%b exp=0", t, commit_valid); end
         tick();
      end
      complete_valid = 1'b0;
      for (int t = 0; t < 3; t++) begin
         exp_r = 32'h1 << (10 + t);
         checks++; if (commit_valid !== 1'b1 || commit_tag !== 4'(t) || return_r_list !== exp_r) begin
            errors++; $display("FAIL ooo_commit_order commit=%b tag=%0d r=%h exp commit=1 tag=%0d r=%h", commit_valid, commit_tag, return_r_list, t, exp_r);
         end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got=%b exp=1", empty); end
   endtask

   task automatic test_full_stall();
      bit seen;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         alloc_valid = 1'b1;
         tick();
      end
      alloc_use_rw = 1'b1; alloc_prev_rw = 5'd7;
      checks++; if (stall !== 1'b1 || alloc_tag !== 4'd0) begin errors++; $display("FAIL full_stall stall=%b tag=%0d exp stall=1 tag=0", stall, alloc_tag); end
      tick();
      checks++; if (stall !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL full_stall_hold stall=%b commit=%b exp stall=1 commit=0", stall, commit_valid); end
      complete_valid = 1'b1; complete_tag = 4'd0;
      tick();
      complete_valid = 1'b0;
      checks++; if (stall !== 1'b1 || commit_valid !== 1'b1 || commit_tag !== 4'd0) begin
         errors++; $display("FAIL full_commit_stall stall=%b commit=%b tag=%0d exp stall=1 commit=1 tag=0", stall, commit_valid, commit_tag);
      end
      checks++; if (return_r_list !== 32'h0) begin errors++; $display("FAIL full_stalled_no_write r=%h exp=0", return_r_list); end
      tick();
      checks++; if (stall !== 1'b0 || alloc_tag !== 4'd0 || commit_valid !== 1'b0) begin
         errors++; $display("FAIL full_accept stall=%b tag=%0d commit=%b exp stall=0 tag=0 commit=0", stall, alloc_tag, commit_valid);
      end
      tick();
      idle_inputs();
      checks++; if (alloc_tag !== 4'd1) begin errors++; $display("FAIL full_tail_advance got=%0d exp=1", alloc_tag); end
      for (int i = 1; i <= 16; i++) begin
         complete_valid = 1'b1; complete_tag = 4'(i % 16);
         tick();
      end
      complete_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (commit_valid === 1'b1 && commit_tag === 4'd0) begin
            seen = 1'b1;
            checks++; if (return_r_list !== 32'h0000_0080) begin errors++; $display("FAIL full_wrapped_return r=%h exp=00000080", return_r_list); end
         end
         tick();
      end
      if (!seen) begin errors++; checks++; $display("FAIL full_wrapped_commit timeout got=none exp=tag0 commit"); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", empty); end
   endtask

   task automatic test_status_only();
      apply_reset();
      alloc_valid = 1'b1; alloc_use_rw = 1'b0; alloc_prev_rw = 5'd9;
      alloc_use_rs = 1'b1; alloc_prev_rs = 3'd3;
      tick();
      idle_inputs();
      complete_valid = 1'b1; complete_tag = 4'd0;
      tick();
      complete_valid = 1'b0;
      checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL status_commit got=%b exp=1", commit_valid); end
      checks++; if (return_r_list !== 32'h0 || return_s_list !== 8'h08) begin
         errors++; $display("FAIL status_return r=%h s=%h exp r=00000000 s=08", return_r_list, return_s_list);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         alloc_valid = 1'b1; alloc_use_rw = 1'b1; alloc_prev_rw = 5'(i + 1);
         alloc_use_rs = 1'b1; alloc_prev_rs = 3'(i);
         tick();
      end
      idle_inputs();
      complete_valid = 1'b1; complete_tag = 4'd2; tick();
      complete_tag = 4'd3; tick();
      complete_tag = 4'd0;
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      complete_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++; if (commit_valid !== 1'b0 || return_r_list !== 32'h0 || return_s_list !== 8'h0) begin
            errors++; $display("FAIL midreset_no_return cyc=%0d commit=%b r=%h s=%h exp all 0", c, commit_valid, return_r_list, return_s_list);
         end
         checks++; if (empty !== 1'b1 || alloc_tag !== 4'd0 || commit_tag !== 4'd0) begin
            errors++; $display("FAIL midreset_state cyc=%0d empty=%b alloc_tag=%0d commit_tag=%0d exp 1/0/0", c, empty, alloc_tag, commit_tag);
         end
         tick();
      end
   endtask

   initial begin
      n_rst = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_out_of_order();
      test_full_stall();
      test_status_only();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
